// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter
//   Round-robin arbiter and sequencer sharing one multi-cycle mult/div unit
//   among 8 requesters. The winner is registered into grant_id, which also
//   steers the operand/result muxes. A single-cycle start pulse launches the
//   unit; the cycle the unit reports ready, a one-hot done pulse is returned
//   to the owner.
//
//   Optional: define MULTDIV_ARB_TIMEOUT_EN to abort an operation that stays
//   in BUSY for TIMEOUT cycles without unit_rdy (timeout_err pulse, no done).
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   req[7:0]    in   level request per requester, held until done
//   unit_rdy    in   result-ready from the unit, only looked at in BUSY
//   grant[7:0]  out  one-hot grant to the owner, zero when idle (registered)
//   grant_id    out  binary owner index / mux select (registered)
//   unit_start  out  single-cycle start pulse (registered)
//   done[7:0]   out  one-hot completion pulse (combinational)
//   busy        out  high in START and BUSY (registered)
//   timeout_err out  single-cycle abort pulse, constant 0 without the feature

module multdiv_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       unit_rdy,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       unit_start,
    output logic [7:0] done,
    output logic       busy,
    output logic       timeout_err
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("multdiv_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] last_grant, last_grant_nxt;
    logic [2:0] grant_id_nxt;
    logic [2:0] winner;
    logic [2:0] scan_idx;
    logic       abort;

`ifdef MULTDIV_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == S_START) begin
            tmo_cnt <= '0;
        end else if (state == S_BUSY && !unit_rdy) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // A ready arriving in the limit cycle takes precedence over the abort.
    assign abort = (state == S_BUSY) && !unit_rdy && (tmo_cnt == 8'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    assign timeout_err = abort;

    // Scan from the farthest offset down to the nearest so that the nearest
    // set bit after last_grant overwrites all others. Offset 8 wraps to
    // last_grant itself, giving the previous owner lowest priority.
    always_comb begin
        winner   = last_grant;
        scan_idx = last_grant;
        for (int i = 8; i >= 1; i--) begin
            scan_idx = last_grant + 3'(i);
            if (req[scan_idx]) winner = scan_idx;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_id_nxt   = grant_id;
        last_grant_nxt = last_grant;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant_id_nxt = winner;
                    state_nxt    = S_START;
                end
            end
            S_START: state_nxt = S_BUSY;
            S_BUSY: begin
                // Pointer moves only when the operation ends, done or abort.
                if (unit_rdy || abort) begin
                    last_grant_nxt = grant_id;
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs are computed from next-state so they line up with
    // the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= 3'd7;
            grant_id   <= 3'd0;
            grant      <= 8'h00;
            unit_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            grant      <= (state_nxt == S_IDLE) ? 8'h00 : (8'h01 << grant_id_nxt);
            unit_start <= (state_nxt == S_START);
            busy       <= (state_nxt != S_IDLE);
        end
    end

    assign done = (state == S_BUSY && unit_rdy) ? (8'h01 << grant_id) : 8'h00;

endmodule

// File: tb/tb_multdiv_arbiter.sv
module tb_multdiv_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       unit_rdy = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       unit_start;
    logic [7:0] done;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_last = 7;

    multdiv_arbiter #(.TIMEOUT(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .unit_rdy   (unit_rdy),
        .grant      (grant),
        .grant_id   (grant_id),
        .unit_start (unit_start),
        .done       (done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first requester after the last owner, mod 8.
    function automatic int rr_pick(input int last, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, unit_start, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tmo"}, timeout_err, 0);
    endtask

    // One operation, entered at an IDLE negedge with req already driven.
    // wait_cyc BUSY cycles without ready, then one ready cycle. busy_req is
    // driven during BUSY to exercise dropped or late requests.
    task automatic run_op(input int wait_cyc, input logic [7:0] busy_req);
        int w;
        int got;
        w = rr_pick(model_last, req);
        exp_q.push_back(w);
        @(negedge clock);
        unit_rdy = (wait_cyc == 0);  // ready during START must be ignored
        #1;
        check("start_grant", grant, 32'(1) << w);
        check("start_gid", grant_id, w);
        check("start_pulse", unit_start, 1);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        for (int k = 0; k < wait_cyc; k++) begin
            @(negedge clock);
            req = busy_req;
            #1;
            check("busy_busy", busy, 1);
            check("busy_start", unit_start, 0);
            check("busy_done", done, 0);
            check("busy_gid", grant_id, w);
            check("busy_tmo", timeout_err, 0);
        end
        @(negedge clock);
        req = busy_req;
        unit_rdy = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("done", done, 32'(1) << got);
            check("done_grant", grant, 32'(1) << got);
            check("done_tmo", timeout_err, 0);
            model_last = got;
        end
        @(negedge clock);
        unit_rdy = 1'b0;
        #1;
        check_idle("post");
    endtask

    initial begin
        // Reset state
        #1;
        check_idle("rst");
        check("rst_gid", grant_id, 0);

        @(negedge clock);
        req = 8'h01;
        reset_n = 1'b1;
        run_op(0, 8'h01);

        // Round robin with everyone requesting
        req = 8'hFF;
        for (int n = 0; n < 9; n++) run_op(0, 8'hFF);

        // Single request, ready in the 4th BUSY cycle
        req = 8'h20;
        run_op(3, 8'h20);

        // Wrap/priority: owner 6, then 0 beats 6, then 6 alone
        req = 8'h40;
        run_op(0, 8'h40);
        req = 8'h41;
        run_op(1, 8'h41);
        req = 8'h40;
        run_op(0, 8'h40);

        // Owner 2 drops req during BUSY while requester 3 rises
        req = 8'h04;
        run_op(2, 8'h08);
        run_op(0, 8'h00);

        // Idle with no requests
        for (int n = 0; n < 2; n++) begin
            @(negedge clock);
            #1;
            check_idle("noreq");
        end

        // Asynchronous reset in the middle of BUSY
        req = 8'h10;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_gid", grant_id, 4);
        reset_n = 1'b0;
        unit_rdy = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_gid", grant_id, 0);
        model_last = 7;
        @(negedge clock);
        unit_rdy = 1'b0;
        req = 8'h81;
        reset_n = 1'b1;
        run_op(0, 8'h81);

`ifdef MULTDIV_ARB_TIMEOUT_EN
        // Timeout after 4 BUSY cycles without ready
        req = 8'h06;
        begin
            int w;
            w = rr_pick(model_last, req);
            @(negedge clock);
            #1;
            check("tmo_start_gid", grant_id, w);
            for (int k = 0; k < 3; k++) begin
                @(negedge clock);
                #1;
                check("tmo_wait", timeout_err, 0);
                check("tmo_wait_busy", busy, 1);
            end
            @(negedge clock);
            #1;
            check("tmo_pulse", timeout_err, 1);
            check("tmo_done", done, 0);
            model_last = w;
            @(negedge clock);
            #1;
            check_idle("tmo_post");
        end
        run_op(0, 8'h06);
`else
        // Without the timeout, BUSY waits indefinitely for ready
        req = 8'h02;
        run_op(110, 8'h02);
`endif

        req = 8'h00;
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
